// File: rtl/srq_pkg.sv
// Shared definitions for the parametrised shift-register queue.
//   SRQ_DEFAULT_WIDTH : default data width of one queue entry
//   srq_err_t         : sticky error flag pair {overflow, underflow}
//   srq_cnt_w()       : width of an occupancy counter able to hold 0..depth
package srq_pkg;

  localparam int SRQ_DEFAULT_WIDTH = 1024;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } srq_err_t;

  function automatic int srq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/srq_stage.sv
// One slot of the shift-register queue.
// Ports:
//   clk_i          : clock, all updates on posedge
//   rst_ni         : synchronous active-low reset (clears valid only)
//   clear_i        : synchronous flush of the valid bit
//   load_i         : take load_data_i from the previous stage (or push)
//   load_data_i    : data offered by the previous stage
//   direct_load_i  : take direct_data_i (fall-through write into the tail)
//   direct_data_i  : data for the direct load
//   move_i         : this slot hands its entry onward at the edge
//   valid_o        : slot holds a valid entry
//   data_o         : slot data (meaningless while valid_o is low)
module srq_stage
  import srq_pkg::*;
#(
  parameter int WIDTH = SRQ_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             direct_load_i,
  input  logic [WIDTH-1:0] direct_data_i,
  input  logic             move_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;

  // A slot is occupied next cycle if something lands in it, or if it is
  // occupied now and its entry is not moving onward.
  always_comb begin
    valid_d = direct_load_i | load_i | (valid_q & ~move_i);
  end

  // Valid bit carries the reset and flush; clear wins over any load.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Wide data register is deliberately not reset; valid_q qualifies it.
  always_ff @(posedge clk_i) begin
    if (direct_load_i) begin
      data_q <= direct_data_i;
    end else if (load_i) begin
      data_q <= load_data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/param_srq.sv
// Parametrised shift-register queue with bubble compaction, occupancy count,
// almost-full threshold, sticky overflow/underflow flags and synchronous flush.
// Stage 0 is the head (entry point), stage DEPTH-1 is the tail (output).
// Optional feature macro: SRQ_FALL_THROUGH_EN -- a push into an empty queue
// is written straight into the tail stage (out_valid one cycle later).
// Ports:
//   clk_i, rst_ni       : clock and synchronous active-low reset
//   flush_i             : synchronous clear of entries, count and error flags
//   push_i, data_in_i   : write request and data; in_ready_o = accepted
//   pop_i               : consume the tail entry
//   out_valid_o         : tail holds a valid entry, data_out_o is its data
//   full_o, empty_o     : occupancy extremes
//   almost_full_o       : count_o >= AF_THRESH
//   count_o             : number of valid entries
//   overflow_o          : sticky, a push was refused
//   underflow_o         : sticky, a pop was issued with no valid tail
module param_srq
  import srq_pkg::*;
#(
  parameter int WIDTH     = SRQ_DEFAULT_WIDTH,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             data_in_i,
  input  logic                         pop_i,
  output logic                         out_valid_o,
  output logic [WIDTH-1:0]             data_out_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         almost_full_o,
  output logic [srq_cnt_w(DEPTH)-1:0]  count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int CW = srq_cnt_w(DEPTH);

  logic [DEPTH-1:0] stageValid;
  logic [WIDTH-1:0] stageData [DEPTH];
  logic [DEPTH-1:0] moveVec;
  logic [DEPTH-1:0] freeVec;

  logic             pushAcc;
  logic             popAcc;
  logic             pushHead;
  logic             pushTail;

  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  srq_err_t         err_q;
  srq_err_t         err_d;

  // Move chain, resolved from the tail back to the head. The tail frees up
  // only when it is popped; every other stage frees up when it is empty or
  // its own entry is moving, which lets a pop ripple through a full queue.
  always_comb begin
    moveVec = '0;
    freeVec = '0;
    moveVec[DEPTH-1] = stageValid[DEPTH-1] & pop_i;
    freeVec[DEPTH-1] = ~stageValid[DEPTH-1] | moveVec[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      moveVec[i] = stageValid[i] & freeVec[i+1];
      freeVec[i] = ~stageValid[i] | moveVec[i];
    end
  end

  assign in_ready_o = freeVec[0];

  // Flush outranks push: a push in the flush cycle is simply dropped.
  assign pushAcc = push_i & freeVec[0] & ~flush_i;
  assign popAcc  = pop_i & stageValid[DEPTH-1];

`ifdef SRQ_FALL_THROUGH_EN
  // Only an empty queue may bypass the chain, so ordering is preserved.
  assign pushTail = pushAcc & empty_o;
  assign pushHead = pushAcc & ~empty_o;
`else
  assign pushTail = 1'b0;
  assign pushHead = pushAcc;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             loadIn;
    logic [WIDTH-1:0] loadData;
    logic             directIn;

    if (i == 0) begin : g_head
      assign loadIn   = pushHead;
      assign loadData = data_in_i;
    end else begin : g_body
      assign loadIn   = moveVec[i-1];
      assign loadData = stageData[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign directIn = pushTail;
    end else begin : g_notail
      assign directIn = 1'b0;
    end

    srq_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (flush_i),
      .load_i        (loadIn),
      .load_data_i   (loadData),
      .direct_load_i (directIn),
      .direct_data_i (data_in_i),
      .move_i        (moveVec[i]),
      .valid_o       (stageValid[i]),
      .data_o        (stageData[i])
    );
  end

  // Occupancy tracks accepted pushes and pops; a simultaneous pair cancels.
  always_comb begin
    count_d = count_q;
    unique case ({pushAcc, popAcc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Error flags only ever set here; they are cleared by reset or flush.
  always_comb begin
    err_d           = err_q;
    err_d.overflow  = err_q.overflow  | (push_i & ~freeVec[0]);
    err_d.underflow = err_q.underflow | (pop_i & ~stageValid[DEPTH-1]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      count_q <= '0;
      err_q   <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_valid_o   = stageValid[DEPTH-1];
  assign data_out_o    = stageData[DEPTH-1];
  assign count_o       = count_q;
  assign full_o        = (count_q == CW'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign almost_full_o = (count_q >= CW'(AF_THRESH));
  assign overflow_o    = err_q.overflow;
  assign underflow_o   = err_q.underflow;

endmodule

// File: tb/tb_param_srq.sv
// Directed self-checking bench for param_srq (DEPTH=4, AF_THRESH=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 more
// unit later, well clear of the next rising edge.
module tb_param_srq;

  localparam int W   = 16;
  localparam int D   = 4;
  localparam int AF  = 3;
  localparam int CW  = $clog2(D + 1);
`ifdef SRQ_FALL_THROUGH_EN
  localparam int LAT = 1;
`else
  localparam int LAT = D;
`endif

  logic          clk = 1'b0;
  logic          rstN;
  logic          flush;
  logic          push;
  logic          inReady;
  logic [W-1:0]  dataIn;
  logic          pop;
  logic          outValid;
  logic [W-1:0]  dataOut;
  logic          full;
  logic          empty;
  logic          almostFull;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  param_srq #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AF_THRESH (AF)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .flush_i       (flush),
    .push_i        (push),
    .in_ready_o    (inReady),
    .data_in_i     (dataIn),
    .pop_i         (pop),
    .out_valid_o   (outValid),
    .data_out_o    (dataOut),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (almostFull),
    .count_o       (count),
    .overflow_o    (overflow),
    .underflow_o   (underflow)
  );

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic doPush, input logic doPop,
                               input logic doFlush, input logic [W-1:0] din);
    push   = doPush;
    pop    = doPop;
    flush  = doFlush;
    dataIn = din;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] expPop [4];
    expPop[0] = 16'd2;
    expPop[1] = 16'd3;
    expPop[2] = 16'd4;
    expPop[3] = 16'd5;

    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Reset: two cycles held low
    tick();
    tick();
    rstN = 1'b1;
    #1;
    checkOutput("rst_empty",     64'(empty),      64'(1));
    checkOutput("rst_count",     64'(count),      64'(0));
    checkOutput("rst_in_ready",  64'(inReady),    64'(1));
    checkOutput("rst_out_valid", 64'(outValid),   64'(0));
    checkOutput("rst_full",      64'(full),       64'(0));
    checkOutput("rst_afull",     64'(almostFull), 64'(0));
    checkOutput("rst_overflow",  64'(overflow),   64'(0));
    checkOutput("rst_underflow", 64'(underflow),  64'(0));

    // Latency: single push of 0xA5 into an empty queue
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hA5);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    for (int k = 1; k <= D; k++) begin
      checkOutput($sformatf("lat_valid_c%0d", k), 64'(outValid), 64'(k >= LAT));
      if (k < D) tick();
    end
    checkOutput("lat_data", 64'(dataOut), 64'h00A5);
    checkOutput("lat_count", 64'(count), 64'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("lat_drain_empty", 64'(empty), 64'(1));

    // Fill with 1..4, no pops
    for (int k = 1; k <= D; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, W'(k));
      checkOutput($sformatf("fill_ready_%0d", k), 64'(inReady), 64'(1));
      tick();
      checkOutput($sformatf("fill_afull_%0d", k), 64'(almostFull), 64'(k >= AF));
      checkOutput($sformatf("fill_full_%0d", k), 64'(full), 64'(k == D));
    end
    checkOutput("fill_count", 64'(count), 64'(4));
    checkOutput("fill_head_data", 64'(dataOut), 64'(1));

    // Fifth push without a pop is refused
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd5);
    checkOutput("ovf_in_ready", 64'(inReady), 64'(0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("ovf_flag", 64'(overflow), 64'(1));
    checkOutput("ovf_count", 64'(count), 64'(4));
    checkOutput("ovf_data", 64'(dataOut), 64'(1));
    tick();
    checkOutput("ovf_sticky", 64'(overflow), 64'(1));

    // Full: push 5 and pop together
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd5);
    checkOutput("fpp_in_ready", 64'(inReady), 64'(1));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("fpp_count", 64'(count), 64'(4));
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("fpp_pop_%0d", k), 64'(dataOut), 64'(expPop[k]));
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("fpp_empty", 64'(empty), 64'(1));
    checkOutput("fpp_ovf_kept", 64'(overflow), 64'(1));

    // Underflow: pop while empty
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("udf_flag", 64'(underflow), 64'(1));
    checkOutput("udf_count", 64'(count), 64'(0));
    checkOutput("udf_out_valid", 64'(outValid), 64'(0));
    checkOutput("udf_in_ready", 64'(inReady), 64'(1));

    // Flush with 3 entries and overflow set, plus a push of 0x7 in the same cycle
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, W'(16'h11 * (k + 1)));
      tick();
    end
    checkOutput("fl_pre_count", 64'(count), 64'(3));
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h7);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("fl_empty", 64'(empty), 64'(1));
    checkOutput("fl_count", 64'(count), 64'(0));
    checkOutput("fl_overflow", 64'(overflow), 64'(0));
    checkOutput("fl_underflow", 64'(underflow), 64'(0));
    for (int k = 0; k <= D; k++) begin
      checkOutput($sformatf("fl_no7_c%0d", k), 64'(outValid), 64'(0));
      tick();
    end

    // Reset mid-operation discards entries like a flush
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h40);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h41);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("mid_pre_count", 64'(count), 64'(2));
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    #1;
    checkOutput("mid_rst_empty", 64'(empty), 64'(1));
    checkOutput("mid_rst_count", 64'(count), 64'(0));
    for (int k = 0; k <= D; k++) begin
      checkOutput($sformatf("mid_rst_nov_c%0d", k), 64'(outValid), 64'(0));
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
